// File: rtl/snn_aer_pkg.sv
// Shared types and sizing helpers for the AER output responder.
// Optional feature macro: AER_TIMESTAMP_EN (adds a timestamp field to each FIFO entry).
package snn_aer_pkg;

    // Handshake FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELAY   = 2'd1,
        ACK_HI  = 2'd2,
        WAIT_LO = 2'd3
    } aer_state_e;

    // ACK latency counter width (ACK_DELAY range 0..63)
    localparam int unsigned DLY_W = 6;

`ifdef AER_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    // FIFO pointer width for a given depth
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Stored entry width: address, plus timestamp when enabled
    function automatic int unsigned entry_width(input int unsigned aer_w, input int unsigned ts_w);
        return aer_w + (TS_EN ? ts_w : 0);
    endfunction

endpackage

// File: rtl/aer_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered full/empty/level.
module aer_sync_fifo
    import snn_aer_pkg::*;
#(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 16
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        WR_EN,
    input  logic [WIDTH-1:0]            WR_DATA,
    input  logic                        RD_EN,
    output logic [WIDTH-1:0]            RD_DATA,
    output logic                        EMPTY,
    output logic                        FULL,
    output logic [ptr_width(DEPTH):0]   LEVEL
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             empty_q;
    logic             full_q;
    logic             do_wr;
    logic             do_rd;

    // A read of an empty FIFO is ignored; a write into a full FIFO needs a same-cycle read
    assign do_rd = RD_EN && !empty_q;
    assign do_wr = WR_EN && (!full_q || do_rd);

    // Next occupancy
    always_comb begin
        level_d = level_q;
        if (do_wr && !do_rd) begin
            level_d = level_q + LVL_W'(1);
        end else if (!do_wr && do_rd) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Pointers, occupancy and flags
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
            empty_q <= (level_d == '0);
            full_q  <= (level_d == LVL_W'(DEPTH));
        end
    end

    // Storage array; contents are only observable while non-empty
    always_ff @(posedge CLK) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= WR_DATA;
        end
    end

    assign RD_DATA = empty_q ? '0 : mem[rd_ptr_q];
    assign EMPTY   = empty_q;
    assign FULL    = full_q;
    assign LEVEL   = level_q;

endmodule

// File: rtl/aer_out_responder.sv
// AER output-side 4-phase handshake responder with event FIFO and per-sample counters.
// Optional feature macro: AER_TIMESTAMP_EN (free-running timestamp stored with each event).
module aer_out_responder
    import snn_aer_pkg::*;
#(
    parameter int unsigned AER_WIDTH      = 12,
    parameter int unsigned ACK_DELAY      = 6,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned DROP_WHEN_FULL = 0,
    parameter int unsigned TS_WIDTH       = 16
) (
    input  logic                                        CLK,
    input  logic                                        RST_N,
    input  logic [AER_WIDTH-1:0]                        AEROUT_ADDR,
    input  logic                                        AEROUT_REQ,
    output logic                                        AEROUT_ACK,
    input  logic                                        CLEAR,
    input  logic                                        FIFO_RD_EN,
    output logic [entry_width(AER_WIDTH, TS_WIDTH)-1:0] FIFO_RD_DATA,
    output logic                                        FIFO_EMPTY,
    output logic                                        FIFO_FULL,
    output logic [ptr_width(FIFO_DEPTH):0]              FIFO_LEVEL,
    output logic [CNT_WIDTH-1:0]                        EVENT_CNT,
    output logic [CNT_WIDTH-1:0]                        DROP_CNT,
    output logic                                        BUSY
);

    localparam int unsigned ENTRY_W = entry_width(AER_WIDTH, TS_WIDTH);
    localparam logic [DLY_W-1:0] DLY_LOAD = (ACK_DELAY > 0) ? DLY_W'(ACK_DELAY - 1) : '0;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    aer_state_e            state_q;
    aer_state_e            state_d;
    logic [DLY_W-1:0]      dly_q;
    logic [DLY_W-1:0]      dly_d;
    logic                  ack_q;
    logic                  ack_d;
    logic                  busy_q;
    logic [CNT_WIDTH-1:0]  ev_q;
    logic [CNT_WIDTH-1:0]  ev_d;
    logic [CNT_WIDTH-1:0]  drop_q;
    logic [CNT_WIDTH-1:0]  drop_d;
    logic                  store;
    logic                  dropped;
    logic                  fifo_full;
    logic [ENTRY_W-1:0]    wr_data;

`ifdef AER_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]   ts_q;

    // Free-running timestamp, zeroed at reset and at each sample boundary
    always_ff @(posedge CLK) begin
        if (!RST_N || CLEAR) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_WIDTH'(1);
        end
    end

    assign wr_data = {ts_q, AEROUT_ADDR};
`else
    assign wr_data = AEROUT_ADDR;
`endif

    // Handshake next-state, capture decision and ACK level
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        ack_d   = ack_q;
        store   = 1'b0;
        dropped = 1'b0;
        case (state_q)
            IDLE: begin
                if (AEROUT_REQ) begin
                    if (!fifo_full || FIFO_RD_EN) begin
                        store = 1'b1;
                    end else if (DROP_WHEN_FULL != 0) begin
                        dropped = 1'b1;
                    end
                    if (store || dropped) begin
                        if (ACK_DELAY > 0) begin
                            state_d = DELAY;
                            dly_d   = DLY_LOAD;
                        end else begin
                            state_d = ACK_HI;
                        end
                    end
                end
            end
            DELAY: begin
                if (dly_q == '0) begin
                    state_d = ACK_HI;
                end else begin
                    dly_d = dly_q - DLY_W'(1);
                end
            end
            ACK_HI: begin
                ack_d   = 1'b1;
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (!AEROUT_REQ) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    // Saturating counters; a coincident CLEAR is applied before the increment
    always_comb begin
        ev_d   = CLEAR ? '0 : ev_q;
        drop_d = CLEAR ? '0 : drop_q;
        if (store && (ev_d != CNT_MAX)) begin
            ev_d = ev_d + CNT_WIDTH'(1);
        end
        if (dropped && (drop_d != CNT_MAX)) begin
            drop_d = drop_d + CNT_WIDTH'(1);
        end
    end

    // State, ACK, BUSY and counter registers
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            dly_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            ev_q    <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            ack_q   <= ack_d;
            busy_q  <= (state_d != IDLE);
            ev_q    <= ev_d;
            drop_q  <= drop_d;
        end
    end

    aer_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .WR_EN   (store),
        .WR_DATA (wr_data),
        .RD_EN   (FIFO_RD_EN),
        .RD_DATA (FIFO_RD_DATA),
        .EMPTY   (FIFO_EMPTY),
        .FULL    (fifo_full),
        .LEVEL   (FIFO_LEVEL)
    );

    assign FIFO_FULL  = fifo_full;
    assign AEROUT_ACK = ack_q;
    assign BUSY       = busy_q;
    assign EVENT_CNT  = ev_q;
    assign DROP_CNT   = drop_q;

endmodule

// File: tb/tb_aer_out_responder.sv
// Randomised scoreboard bench for aer_out_responder.
// Instance 0: ACK_DELAY=6, depth 4, stall when full. Instance 1: ACK_DELAY=0, depth 4, drop when full, 3-bit counters.
module tb_aer_out_responder;

`ifdef AER_TIMESTAMP_EN
    localparam int DW = 28;
`else
    localparam int DW = 12;
`endif
    localparam int DEPTH = 4;

    function automatic int dly_of(input int d);
        return (d == 0) ? 6 : 0;
    endfunction
    function automatic int cmax_of(input int d);
        return (d == 0) ? 65535 : 7;
    endfunction
    function automatic bit drop_of(input int d);
        return (d == 1);
    endfunction

    logic          clk;
    logic          rst_n;
    logic          clear;
    logic          req    [2];
    logic [11:0]   addr   [2];
    logic          rd_en  [2];
    logic          ack    [2];
    logic [DW-1:0] rdata  [2];
    logic          empty  [2];
    logic          full   [2];
    logic [2:0]    level  [2];
    logic [15:0]   evc    [2];
    logic [15:0]   dropc  [2];
    logic          busy   [2];
    logic [2:0]    ev1;
    logic [2:0]    dr1;

    assign evc[1]   = 16'(ev1);
    assign dropc[1] = 16'(dr1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    aer_out_responder #(
        .AER_WIDTH(12), .ACK_DELAY(6), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(16),
        .DROP_WHEN_FULL(0), .TS_WIDTH(16)
    ) u_dut0 (
        .CLK(clk), .RST_N(rst_n), .AEROUT_ADDR(addr[0]), .AEROUT_REQ(req[0]),
        .AEROUT_ACK(ack[0]), .CLEAR(clear), .FIFO_RD_EN(rd_en[0]),
        .FIFO_RD_DATA(rdata[0]), .FIFO_EMPTY(empty[0]), .FIFO_FULL(full[0]),
        .FIFO_LEVEL(level[0]), .EVENT_CNT(evc[0]), .DROP_CNT(dropc[0]), .BUSY(busy[0])
    );

    aer_out_responder #(
        .AER_WIDTH(12), .ACK_DELAY(0), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(3),
        .DROP_WHEN_FULL(1), .TS_WIDTH(16)
    ) u_dut1 (
        .CLK(clk), .RST_N(rst_n), .AEROUT_ADDR(addr[1]), .AEROUT_REQ(req[1]),
        .AEROUT_ACK(ack[1]), .CLEAR(clear), .FIFO_RD_EN(rd_en[1]),
        .FIFO_RD_DATA(rdata[1]), .FIFO_EMPTY(empty[1]), .FIFO_FULL(full[1]),
        .FIFO_LEVEL(level[1]), .EVENT_CNT(ev1), .DROP_CNT(dr1), .BUSY(busy[1])
    );

    // Reference model state (edge-level, derived from the handshake rules)
    int            cyc = 0;
    bit            in_reset = 1'b1;
    int            mcount   [2];
    int            mev      [2];
    int            mdrop    [2];
    bit            exp_ack  [2];
    bit            exp_busy [2];
    bit            pending  [2];
    bit            prev_req [2];
    int            rise_at  [2];
    logic [15:0]   mts      [2];
    logic [DW-1:0] expq     [2][$];

    int  n_checks = 0;
    int  n_fail   = 0;
    int  tmo_cnt  = 0;
    int  rnd_done = 0;
    bit  mon_en   = 1'b0;
    bit  fin      = 1'b0;

    // Model: applies reset, ACK timing, capture/drop and FIFO occupancy at each edge
    initial begin
        for (int d = 0; d < 2; d++) begin
            mcount[d] = 0; mev[d] = 0; mdrop[d] = 0; exp_ack[d] = 0; exp_busy[d] = 0;
            pending[d] = 0; prev_req[d] = 0; rise_at[d] = -1; mts[d] = '0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            in_reset = !rst_n;
            for (int d = 0; d < 2; d++) begin
                bit rd_ok;
                bit st;
                bit dr;
                int base;
                logic [DW-1:0] ent;
                if (!rst_n) begin
                    mcount[d] = 0; mev[d] = 0; mdrop[d] = 0; exp_ack[d] = 0; exp_busy[d] = 0;
                    pending[d] = 0; rise_at[d] = -1; mts[d] = '0;
                    expq[d].delete();
                end else begin
                    st = 0;
                    dr = 0;
                    if (rise_at[d] == cyc) begin
                        exp_ack[d] = 1;
                        rise_at[d] = -1;
                    end else if (exp_ack[d] && !req[d]) begin
                        exp_ack[d]  = 0;
                        exp_busy[d] = 0;
                    end
                    rd_ok = rd_en[d] && (mcount[d] > 0);
                    if (req[d] && !prev_req[d]) pending[d] = 1;
                    if (pending[d] && req[d]) begin
                        if (mcount[d] < DEPTH || rd_ok) st = 1;
                        else if (drop_of(d)) dr = 1;
                        if (st || dr) begin
                            pending[d]  = 0;
                            exp_busy[d] = 1;
                            rise_at[d]  = cyc + 1 + dly_of(d);
                        end
                    end
                    if (rd_ok) mcount[d]--;
`ifdef AER_TIMESTAMP_EN
                    ent = {mts[d], addr[d]};
`else
                    ent = addr[d];
`endif
                    if (st) begin
                        mcount[d]++;
                        expq[d].push_back(ent);
                    end
                    base = clear ? 0 : mev[d];
                    if (st && base < cmax_of(d)) base++;
                    mev[d] = base;
                    base = clear ? 0 : mdrop[d];
                    if (dr && base < cmax_of(d)) base++;
                    mdrop[d] = base;
                    mts[d] = clear ? 16'h0 : mts[d] + 16'h1;
                end
                prev_req[d] = req[d];
            end
        end
    end

    task automatic chk(input string nm, input int d, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got=%0h exp=%0h cycle=%0d", nm, d, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT outputs against the model and pops expected FIFO data on reads
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int d = 0; d < 2; d++) begin
                    chk("ack",   d, longint'(ack[d]),   longint'(exp_ack[d]));
                    chk("busy",  d, longint'(busy[d]),  longint'(exp_busy[d]));
                    chk("level", d, longint'(level[d]), longint'(mcount[d]));
                    chk("empty", d, longint'(empty[d]), longint'(mcount[d] == 0));
                    chk("full",  d, longint'(full[d]),  longint'(mcount[d] == DEPTH));
                    chk("evcnt", d, longint'(evc[d]),   longint'(mev[d]));
                    chk("dropcnt", d, longint'(dropc[d]), longint'(mdrop[d]));
                    if (in_reset) chk("rst_data", d, longint'(rdata[d]), 0);
                    if (rd_en[d] && !empty[d] && rst_n) begin
                        if (expq[d].size() == 0) begin
                            chk("data_extra", d, longint'(rdata[d]), -1);
                        end else begin
                            chk("rd_data", d, longint'(rdata[d]), longint'(expq[d].pop_front()));
                        end
                    end
                end
            end
            if (fin) begin
                chk("timeouts", 0, longint'(tmo_cnt), 0);
                $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
                $finish;
            end
        end
    end

    // One full 4-phase handshake on instance d, REQ held 'hold' cycles after ACK
    task automatic hs(input int d, input logic [11:0] a, input int hold);
        int n;
        @(posedge clk); #1;
        addr[d] = a;
        req[d]  = 1'b1;
        n = 0;
        while (ack[d] !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        if (n >= 400) tmo_cnt++;
        for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
        req[d] = 1'b0;
        n = 0;
        while (ack[d] !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
        if (n >= 40) tmo_cnt++;
        addr[d] = 12'($urandom);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1; clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; addr[d] = '0; rd_en[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        cycles(2);
        rst_n = 1'b1;
        cycles(5);

        // Single handshake with 6-cycle latency, REQ dropped 2 cycles after ACK
        hs(0, 12'h123, 2);
        cycles(3);

        // 20 back-to-back zero-latency handshakes with continuous reads
        rd_en[1] = 1'b1;
        for (int i = 0; i < 20; i++) hs(1, 12'(i), 0);
        cycles(3);
        rd_en[1] = 1'b0;

        // Drain instance 0, then fill it to stall the fifth request until one read
        rd_en[0] = 1'b1;
        cycles(3);
        rd_en[0] = 1'b0;
        for (int i = 0; i < 4; i++) hs(0, 12'(12'h200 + i), 1);
        fork
            hs(0, 12'h204, 1);
            begin
                cycles(30);
                rd_en[0] = 1'b1;
                cycles(1);
                rd_en[0] = 1'b0;
            end
        join

        // Drop-when-full: 6 events into an empty depth-4 FIFO, no reads
        pulse_clear();
        for (int i = 0; i < 6; i++) hs(1, 12'(12'h300 + i), 0);
        cycles(2);

        // Three more stored events on instance 0 (reads on), then CLEAR on a capture edge
        rd_en[0] = 1'b1;
        for (int i = 0; i < 3; i++) hs(0, 12'(12'h400 + i), 0);
        rd_en[0] = 1'b0;
        cycles(4);
        fork
            pulse_clear();
            hs(0, 12'h4AA, 1);
        join
        cycles(3);

        // Randomised traffic on both instances with random reads and clears
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    cycles($urandom_range(0, 2));
                    hs(0, 12'($urandom), $urandom_range(0, 3));
                end
                rnd_done++;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    cycles($urandom_range(0, 2));
                    hs(1, 12'($urandom), $urandom_range(0, 3));
                end
                rnd_done++;
            end
            begin
                for (int c = 0; c < 6000 && rnd_done < 2; c++) begin
                    @(posedge clk); #1;
                    rd_en[0] = ($urandom_range(0, 2) == 0);
                    rd_en[1] = ($urandom_range(0, 3) == 0);
                    clear    = ($urandom_range(0, 39) == 0);
                end
                rd_en[0] = 1'b0;
                rd_en[1] = 1'b0;
                clear    = 1'b0;
            end
        join
        cycles(3);

        // Reset while instance 0 is counting down its ACK latency
        @(posedge clk); #1;
        addr[0] = 12'h777;
        req[0]  = 1'b1;
        cycles(3);
        rst_n  = 1'b0;
        req[0] = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        hs(0, 12'h5A5, 1);
        hs(1, 12'h0A5, 1);

        // Drain both FIFOs so every stored entry is compared
        rd_en[0] = 1'b1;
        rd_en[1] = 1'b1;
        cycles(8);
        rd_en[0] = 1'b0;
        rd_en[1] = 1'b0;
        cycles(2);
        fin = 1'b1;
    end

    // Absolute bound on simulation time
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
